// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 scan-code constants and the break/extended decoder state type.
package ps2_keys_pkg;

   localparam logic [7:0] BREAK     = 8'hF0;
   localparam logic [7:0] EXT       = 8'hE0;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_BKSP  = 8'h66;
   localparam logic [7:0] KEY_ESC   = 8'h76;

   // States are prefixed so they do not collide with the EXT scan-code constant.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } ps2_state_t;

endpackage

// File: rtl/hex_word_fifo.sv
// Small synchronous FIFO for committed words; head word is shown combinationally.
module hex_word_fifo #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the current level, so a same-cycle pop never rescues a push into a full FIFO.
   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/ps2_to_hex.sv
// Combinational decoder from PS/2 set-2 main-row scan codes to a hex digit.
module ps2_to_hex (
   input  logic [7:0] scan_code,
   output logic [3:0] hex,
   output logic       is_hex
);

   // Lookup of the sixteen hex keys; anything else reports is_hex = 0.
   always_comb begin
      hex    = 4'h0;
      is_hex = 1'b1;
      case (scan_code)
         8'h45: hex = 4'h0;
         8'h16: hex = 4'h1;
         8'h1E: hex = 4'h2;
         8'h26: hex = 4'h3;
         8'h25: hex = 4'h4;
         8'h2E: hex = 4'h5;
         8'h36: hex = 4'h6;
         8'h3D: hex = 4'h7;
         8'h3E: hex = 4'h8;
         8'h46: hex = 4'h9;
         8'h1C: hex = 4'hA;
         8'h32: hex = 4'hB;
         8'h21: hex = 4'hC;
         8'h23: hex = 4'hD;
         8'h24: hex = 4'hE;
         8'h2B: hex = 4'hF;
         default: is_hex = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_hex_entry_fifo.sv
// PS/2 hex-entry front end: break-code decoding, digit accumulation and a commit FIFO.
module ps2_hex_entry_fifo
   import ps2_keys_pkg::*;
#(
   parameter  int NIBBLES  = 8,
   parameter  int DEPTH    = 4,
   parameter  int SHIFT_IN = 1,
   localparam int W        = 4 * NIBBLES,
   localparam int CW       = $clog2(NIBBLES + 1),
   localparam int LW       = $clog2(DEPTH + 1)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic [7:0]    scan_data,
   input  logic          scan_valid,
   output logic [W-1:0]  entry_value,
   output logic [CW-1:0] digit_count,
   output logic          did_change,
   output logic          enter,
   output logic          submit,
   output logic          reject,
   output logic [W-1:0]  word_data,
   output logic          word_last,
   output logic          word_valid,
   input  logic          word_ready,
   output logic [LW-1:0] fifo_level
);

   ps2_state_t    state;
   ps2_state_t    state_next;
   logic          act_valid;
   logic [7:0]    act_code;
   logic [3:0]    key_hex;
   logic          key_is_hex;
   logic          fifo_full;
   logic          fifo_empty;
   logic [W:0]    head;
   logic          push;
   logic [W:0]    push_word;
   logic [W-1:0]  entry_next;
   logic [CW-1:0] count_next;
   logic          change_next;
   logic          enter_next;
   logic          submit_next;
   logic          reject_next;

   ps2_to_hex u_decode (
      .scan_code (act_code),
      .hex       (key_hex),
      .is_hex    (key_is_hex)
   );

   hex_word_fifo #(
      .WIDTH (W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLOCK_50),
      .rst       (reset),
      .push      (push),
      .push_data (push_word),
      .pop       (word_ready),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign word_data  = head[W-1:0];
   assign word_last  = head[W];
   assign word_valid = !fifo_empty;

   // Decoder state register; a reset drops any half-received prefix.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Prefix tracking: only a released key (or keypad Enter release) produces an action.
   always_comb begin
      state_next = state;
      act_valid  = 1'b0;
      act_code   = scan_data;
      if (scan_valid) begin
         case (state)
            ST_IDLE: begin
               if (scan_data == BREAK)    state_next = ST_BRK;
               else if (scan_data == EXT) state_next = ST_EXT;
            end
            ST_BRK: begin
               act_valid  = 1'b1;
               state_next = ST_IDLE;
            end
            ST_EXT: begin
               state_next = (scan_data == BREAK) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_EXT_BRK: begin
               act_valid  = (scan_data == KEY_ENTER);
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Work out the effect of a released key on the entry word, the pulses and the FIFO.
   always_comb begin
      entry_next  = entry_value;
      count_next  = digit_count;
      change_next = 1'b0;
      enter_next  = 1'b0;
      submit_next = 1'b0;
      reject_next = 1'b0;
      push        = 1'b0;
      push_word   = {1'b0, entry_value};
      if (act_valid) begin
         if (key_is_hex) begin
            if (digit_count < CW'(NIBBLES)) begin
               if (SHIFT_IN != 0) begin
                  entry_next = (entry_value << 4) | W'(key_hex);
               end else begin
                  for (int i = 0; i < NIBBLES; i++)
                     if (i == int'(digit_count)) entry_next[4*i +: 4] = key_hex;
               end
               count_next  = digit_count + CW'(1);
               change_next = 1'b1;
            end else begin
               reject_next = 1'b1;
            end
         end else begin
            case (act_code)
               KEY_BKSP: begin
                  if (digit_count != '0) begin
                     if (SHIFT_IN != 0) begin
                        entry_next = entry_value >> 4;
                     end else begin
                        for (int i = 0; i < NIBBLES; i++)
                           if (i == int'(digit_count) - 1) entry_next[4*i +: 4] = 4'h0;
                     end
                     count_next  = digit_count - CW'(1);
                     change_next = 1'b1;
                  end
               end
               KEY_ESC: begin
                  entry_next  = '0;
                  count_next  = '0;
                  change_next = (digit_count != '0);
               end
               KEY_ENTER, KEY_S: begin
                  if (!fifo_full) begin
                     push        = 1'b1;
                     push_word   = {(act_code == KEY_S), entry_value};
                     entry_next  = '0;
                     count_next  = '0;
                     change_next = 1'b1;
                     enter_next  = (act_code == KEY_ENTER);
                     submit_next = (act_code == KEY_S);
                  end else begin
                     reject_next = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Register the entry word and the one-cycle status pulses.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         entry_value <= '0;
         digit_count <= '0;
         did_change  <= 1'b0;
         enter       <= 1'b0;
         submit      <= 1'b0;
         reject      <= 1'b0;
      end else begin
         entry_value <= entry_next;
         digit_count <= count_next;
         did_change  <= change_next;
         enter       <= enter_next;
         submit      <= submit_next;
         reject      <= reject_next;
      end
   end

endmodule

// File: tb/tb_ps2_hex_entry_fifo.sv
// Testbench: two instances (shift-in and positional) driven by one byte stream,
// checked against a key-level model plus fixed vectors for the corner cases.
module tb_ps2_hex_entry_fifo;
   import ps2_keys_pkg::*;

   localparam int NIB = 8;
   localparam int DEP = 4;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [7:0]  scan_data;
   logic        scan_valid;
   logic        word_ready;

   logic [31:0] s_entry, p_entry, s_wdata, p_wdata;
   logic [3:0]  s_count, p_count;
   logic        s_chg, p_chg, s_enter, p_enter, s_submit, p_submit, s_reject, p_reject;
   logic        s_wlast, p_wlast, s_wvalid, p_wvalid;
   logic [2:0]  s_level, p_level;

   ps2_hex_entry_fifo #(.NIBBLES(NIB), .DEPTH(DEP), .SHIFT_IN(1)) u_shift (
      .CLOCK_50(CLOCK_50), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
      .entry_value(s_entry), .digit_count(s_count), .did_change(s_chg), .enter(s_enter),
      .submit(s_submit), .reject(s_reject), .word_data(s_wdata), .word_last(s_wlast),
      .word_valid(s_wvalid), .word_ready(word_ready), .fifo_level(s_level));

   ps2_hex_entry_fifo #(.NIBBLES(NIB), .DEPTH(DEP), .SHIFT_IN(0)) u_pos (
      .CLOCK_50(CLOCK_50), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
      .entry_value(p_entry), .digit_count(p_count), .did_change(p_chg), .enter(p_enter),
      .submit(p_submit), .reject(p_reject), .word_data(p_wdata), .word_last(p_wlast),
      .word_valid(p_wvalid), .word_ready(word_ready), .fifo_level(p_level));

   // Free-running 100 MHz clock.
   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   // Key-level reference model: typed digits, in typing order, plus the committed words.
   typedef struct {
      logic        tag;
      logic [31:0] sv;
      logic [31:0] pv;
   } word_t;

   int    digits[$];
   word_t fq[$];
   bit    e_chg, e_enter, e_submit, e_reject;

   logic [7:0] hexScan [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

   typedef struct {
      logic [7:0]  data;
      bit          act;
      logic [31:0] exp_s;
      logic [31:0] exp_p;
      int          exp_count;
      bit          exp_chg;
   } vec_t;

   vec_t vecs[$];

   function automatic int hexOf(logic [7:0] c);
      for (int i = 0; i < 16; i++) if (hexScan[i] == c) return i;
      return -1;
   endfunction

   // Calculator entry: the most recently typed digit is the least significant.
   function automatic logic [31:0] shiftVal();
      logic [31:0] v = '0;
      foreach (digits[i]) v = (v << 4) | 32'(digits[i]);
      return v;
   endfunction

   // Positional entry: the first typed digit sits in nibble 0.
   function automatic logic [31:0] posVal();
      logic [31:0] v = '0;
      foreach (digits[i]) v = v | (32'(digits[i]) << (4 * i));
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      check("entry_shift", 64'(s_entry), 64'(shiftVal()));
      check("entry_pos", 64'(p_entry), 64'(posVal()));
      check("digit_count", 64'(s_count), 64'(digits.size()));
      check("digit_count_pos", 64'(p_count), 64'(digits.size()));
      check("did_change", 64'(s_chg), 64'(e_chg));
      check("did_change_pos", 64'(p_chg), 64'(e_chg));
      check("enter", 64'(s_enter), 64'(e_enter));
      check("submit", 64'(s_submit), 64'(e_submit));
      check("reject", 64'(s_reject), 64'(e_reject));
      check("word_valid", 64'(s_wvalid), 64'(fq.size() > 0));
      check("fifo_level", 64'(s_level), 64'(fq.size()));
      if (fq.size() > 0) begin
         check("word_data", 64'(s_wdata), 64'(fq[0].sv));
         check("word_data_pos", 64'(p_wdata), 64'(fq[0].pv));
         check("word_last", 64'(s_wlast), 64'(fq[0].tag));
      end
   endtask

   // One clock cycle from a falling edge to the next; 'act' marks the byte that completes a key release.
   task automatic applyStimulus(logic v, logic [7:0] d, bit act, logic rdy);
      bit    fullBefore, doPop, doPush;
      word_t nw;
      int    h;
      scan_valid = v;
      scan_data  = d;
      word_ready = rdy;
      e_chg = 0; e_enter = 0; e_submit = 0; e_reject = 0;
      fullBefore = (fq.size() == DEP);
      doPop      = rdy && (fq.size() > 0);
      doPush     = 0;
      nw         = '{1'b0, 32'h0, 32'h0};
      if (act) begin
         h = hexOf(d);
         if (h >= 0) begin
            if (digits.size() < NIB) begin
               digits.push_back(h);
               e_chg = 1;
            end else begin
               e_reject = 1;
            end
         end else if (d == KEY_BKSP) begin
            if (digits.size() > 0) begin
               void'(digits.pop_back());
               e_chg = 1;
            end
         end else if (d == KEY_ESC) begin
            e_chg = (digits.size() > 0);
            digits.delete();
         end else if (d == KEY_ENTER || d == KEY_S) begin
            if (!fullBefore) begin
               nw = '{(d == KEY_S), shiftVal(), posVal()};
               doPush = 1;
               digits.delete();
               e_chg    = 1;
               e_enter  = (d == KEY_ENTER);
               e_submit = (d == KEY_S);
            end else begin
               e_reject = 1;
            end
         end
      end
      if (doPop)  fq.delete(0);
      if (doPush) fq.push_back(nw);
      @(negedge CLOCK_50);
      scan_valid = 1'b0;
      checkOutput();
   endtask

   task automatic pressKey(logic [7:0] c, logic rdy);
      applyStimulus(1'b1, BREAK, 1'b0, rdy);
      applyStimulus(1'b1, c, 1'b1, rdy);
   endtask

   task automatic extEnter(logic rdy);
      applyStimulus(1'b1, EXT, 1'b0, rdy);
      applyStimulus(1'b1, BREAK, 1'b0, rdy);
      applyStimulus(1'b1, KEY_ENTER, 1'b1, rdy);
   endtask

   // Asserts reset for one cycle while idle; the model forgets everything.
   task automatic doReset();
      scan_valid = 1'b0;
      word_ready = 1'b0;
      reset      = 1'b1;
      digits.delete();
      fq.delete();
      e_chg = 0; e_enter = 0; e_submit = 0; e_reject = 0;
      #1;
      checkOutput();
      @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   function automatic logic rndReady();
      return ($urandom_range(0, 99) < 35);
   endfunction

   task automatic sendByte(logic [7:0] d, bit act);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00, 1'b0, rndReady());
      applyStimulus(1'b1, d, act, rndReady());
   endtask

   function automatic logic [7:0] randomKey();
      int r = $urandom_range(0, 99);
      if (r < 60) return hexScan[$urandom_range(0, 15)];
      if (r < 70) return KEY_BKSP;
      if (r < 75) return KEY_ESC;
      if (r < 85) return KEY_ENTER;
      if (r < 95) return KEY_S;
      return 8'h29;
   endfunction

   logic [31:0] heads [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
   logic        lasts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      reset      = 1'b0;
      scan_data  = 8'h00;
      scan_valid = 1'b0;
      word_ready = 1'b0;
      @(negedge CLOCK_50);
      doReset();

      // Typing 1 2 3, backspace, escape, against fixed expected words.
      vecs.push_back('{8'hF0, 1'b0, 32'h000, 32'h000, 0, 1'b0});
      vecs.push_back('{8'h16, 1'b1, 32'h001, 32'h001, 1, 1'b1});
      vecs.push_back('{8'hF0, 1'b0, 32'h001, 32'h001, 1, 1'b0});
      vecs.push_back('{8'h1E, 1'b1, 32'h012, 32'h021, 2, 1'b1});
      vecs.push_back('{8'hF0, 1'b0, 32'h012, 32'h021, 2, 1'b0});
      vecs.push_back('{8'h26, 1'b1, 32'h123, 32'h321, 3, 1'b1});
      vecs.push_back('{8'hF0, 1'b0, 32'h123, 32'h321, 3, 1'b0});
      vecs.push_back('{8'h66, 1'b1, 32'h012, 32'h021, 2, 1'b1});
      vecs.push_back('{8'hF0, 1'b0, 32'h012, 32'h021, 2, 1'b0});
      vecs.push_back('{8'h76, 1'b1, 32'h000, 32'h000, 0, 1'b1});
      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].data, vecs[i].act, 1'b0);
         check("vec_entry_shift", 64'(s_entry), 64'(vecs[i].exp_s));
         check("vec_entry_pos", 64'(p_entry), 64'(vecs[i].exp_p));
         check("vec_count", 64'(s_count), 64'(vecs[i].exp_count));
         check("vec_did_change", 64'(s_chg), 64'(vecs[i].exp_chg));
      end
      // Escape at count zero: no pulse.
      pressKey(KEY_ESC, 1'b0);
      check("esc_empty_no_change", 64'(s_chg), 64'(0));

      // Nine ones: the ninth is rejected, then Enter commits the full word.
      for (int i = 0; i < 9; i++) pressKey(8'h16, 1'b0);
      check("overflow_reject", 64'(s_reject), 64'(1));
      check("overflow_entry", 64'(s_entry), 64'(32'h11111111));
      check("overflow_count", 64'(s_count), 64'(8));
      pressKey(KEY_ENTER, 1'b0);
      check("commit_enter", 64'(s_enter), 64'(1));
      check("commit_data", 64'(s_wdata), 64'(32'h11111111));
      check("commit_last", 64'(s_wlast), 64'(0));
      check("commit_cleared", 64'(s_entry), 64'(0));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Fill the FIFO while the consumer stalls; the fifth commit bounces.
      pressKey(8'h1C, 1'b0); pressKey(KEY_ENTER, 1'b0);
      pressKey(8'h32, 1'b0); pressKey(KEY_ENTER, 1'b0);
      pressKey(8'h21, 1'b0); pressKey(KEY_ENTER, 1'b0);
      pressKey(8'h23, 1'b0); pressKey(KEY_S, 1'b0);
      check("fill_submit", 64'(s_submit), 64'(1));
      pressKey(8'h24, 1'b0); pressKey(KEY_ENTER, 1'b0);
      check("full_reject", 64'(s_reject), 64'(1));
      check("full_level", 64'(s_level), 64'(4));
      check("full_entry_kept", 64'(s_entry), 64'(32'hE));
      for (int i = 0; i < 4; i++) begin
         check("drain_head", 64'(s_wdata), 64'(heads[i]));
         check("drain_last", 64'(s_wlast), 64'(lasts[i]));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      end
      check("drain_empty", 64'(s_wvalid), 64'(0));
      pressKey(KEY_ESC, 1'b0);

      // Make-only and extended-make bytes are ignored; extended Enter release commits.
      pressKey(8'h3D, 1'b0);
      applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
      applyStimulus(1'b1, EXT, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
      check("ignored_make", 64'(s_entry), 64'(32'h7));
      extEnter(1'b0);
      check("ext_enter", 64'(s_enter), 64'(1));
      check("ext_enter_data", 64'(s_wdata), 64'(32'h7));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of an extended release discards the prefix and the FIFO.
      pressKey(8'h16, 1'b0);
      pressKey(KEY_ENTER, 1'b0);
      pressKey(8'h1E, 1'b0);
      applyStimulus(1'b1, EXT, 1'b0, 1'b0);
      doReset();
      pressKey(KEY_ENTER, 1'b0);
      check("reset_enter", 64'(s_enter), 64'(1));
      check("reset_level", 64'(s_level), 64'(1));
      check("reset_word", 64'(s_wdata), 64'(0));

      // Random key traffic with a randomly stalling consumer.
      for (int n = 0; n < 500; n++) begin
         int          kind = $urandom_range(0, 99);
         logic [7:0]  k    = randomKey();
         if (kind < 70) begin
            sendByte(BREAK, 1'b0);
            sendByte(k, 1'b1);
         end else if (kind < 80) begin
            sendByte(k, 1'b0);
         end else if (kind < 88) begin
            sendByte(EXT, 1'b0);
            sendByte(k, 1'b0);
         end else if (kind < 95) begin
            sendByte(EXT, 1'b0);
            sendByte(BREAK, 1'b0);
            sendByte(KEY_ENTER, 1'b1);
         end else begin
            if (k == KEY_ENTER) k = 8'h29;
            sendByte(EXT, 1'b0);
            sendByte(BREAK, 1'b0);
            sendByte(k, 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_hex_entry_fifo.md
Name: ps2_hex_entry_fifo

Overview:
Parametrised PS/2 hex-entry front end. It consumes the PS/2 controller byte stream and decodes make, break (F0) and extended (E0) sequences. Hex keys are accumulated into a NIBBLES-digit word, with backspace, escape-clear, and two commit keys. Committed words go into a DEPTH-entry FIFO that drains to the processor over a valid/ready handshake, while the live entry value feeds the seven-segment displays.

Parameters:
NIBBLES, 8, hex digits per word (1..8); word width W = 4*NIBBLES
DEPTH, 4, FIFO entries (power of 2, >=2)
SHIFT_IN, 1, 1 = calculator shift-left entry; 0 = positional fill, first digit into nibble 0

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
scan_data  in  8  received_data from PS2_Controller
scan_valid  in  1  received_data_en; one-cycle strobe
entry_value  out  W  live entry word, for the HEX displays
digit_count  out  clog2(NIBBLES+1)  digits currently entered
did_change  out  1  one-cycle pulse when entry_value or digit_count changes
enter  out  1  one-cycle pulse when a word is pushed by Enter
submit  out  1  one-cycle pulse when a word is pushed by S
reject  out  1  one-cycle pulse when a digit or commit is dropped
word_data  out  W  FIFO head word
word_last  out  1  FIFO head tag: 1 = committed by S
word_valid  out  1  FIFO not empty
word_ready  in  1  consumer accepts the head word
fifo_level  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; entry, count and FIFO cleared. Asserting reset mid-sequence discards any partial sequence and all buffered words.
- FSM advances only on scan_valid:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte (make code or typematic repeat) is ignored and stays in IDLE.
  - BRK: the byte is the released key -> ACT; return to IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE.
  - EXT_BRK: 5A (keypad Enter) -> ACT as Enter; any other byte is ignored; return to IDLE.
- Actions are registered. For a break-code byte strobed at cycle t, entry_value, digit_count, pulses and FIFO state update at t+1. word_valid rises at t+1 if the FIFO was empty.
- Hex key (0-9, A-F via the scan-to-hex decode):
  - If count < NIBBLES and SHIFT_IN=1: entry = {entry[W-5:0], hex}.
  - If count < NIBBLES and SHIFT_IN=0: nibble[count] = hex.
  - In both cases count+1 and did_change is pulsed.
  - If count == NIBBLES: entry is unchanged and reject is pulsed.
- Backspace (66): if count > 0, SHIFT_IN=1 shifts entry right 4 bits (zero fill); SHIFT_IN=0 zeroes nibble[count-1]; count-1; did_change is pulsed. At count == 0 it is a no-op with no pulse.
- Escape (76): entry = 0, count = 0. did_change is pulsed only if count was nonzero. Nothing is pushed.
- Enter (5A) / S (1B):
  - If FIFO not full: push {tag, entry}, where tag = 1 for S; entry and count clear; enter or submit is pulsed; did_change is pulsed.
  - If FIFO full: nothing is pushed, entry is kept, reject is pulsed.
  - Count == 0 is still pushed (word 0).
- All other released keys are ignored.
- FIFO:
  - Pop when word_valid && word_ready.
  - Push and pop in the same cycle: legal when not full, and level is unchanged.
  - When full, a push is rejected even if a pop occurs in the same cycle (full is sampled before the pop).
  - Pointers wrap modulo DEPTH.
  - word_data and word_last hold their value while word_valid && !word_ready.
- Pulses are exactly one cycle; at most one action occurs per cycle.

Decomposition:
- Shared package ps2_keys_pkg holds:
  - scan-code constants: BREAK=F0, EXT=E0, KEY_ENTER=5A, KEY_S=1B, KEY_BKSP=66, KEY_ESC=76;
  - the FSM state enum {IDLE, BRK, EXT, EXT_BRK}.
- Reuse the existing ps2_to_hex combinational decoder unchanged.
- One sub-module, hex_word_fifo (parameters W+1, DEPTH), with synchronous push/pop, full, empty and level outputs.

Test Plan:
- Type F0 16, F0 1E, F0 26 (SHIFT_IN=1) -> entry_value=0x123, digit_count=3, three did_change pulses each one cycle after the key byte.
- Same keys with SHIFT_IN=0 -> entry_value=0x321. Then F0 66 -> 0x021, digit_count=2.
- Enter nine digits "1" (NIBBLES=8) -> entry_value=0x11111111; 9th digit pulses reject with entry unchanged. Then F0 5A -> enter pulse, word_data=0x11111111, word_last=0, entry_value=0.
- With word_ready=0, commit 5 words (DEPTH=4) -> fifo_level=4, 5th commit pulses reject and keeps its entry. Raise word_ready -> words drain in order, and the final S-committed word shows word_last=1.
- Make-only 1C (no F0), E0 1C, E0 F0 5A -> first two are ignored; the third acts as Enter and pushes the entry.
- Assert reset between E0 and F0 of an extended break, then send F0 5A -> treated as a normal Enter after reset; FIFO was emptied by reset and now has level 1 holding word 0.
